// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: constants, field positions, a class helper and the
// operand-sequencer state encoding.
package fp16_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  // Field positions within a binary16 word
  localparam int unsigned FP16_SIGN_BIT = 15;
  localparam int unsigned FP16_EXP_MSB  = 14;
  localparam int unsigned FP16_EXP_LSB  = 10;
  localparam int unsigned FP16_MAN_MSB  = 9;
  localparam int unsigned FP16_MAN_LSB  = 0;
  localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;

  // Sequencer states (plain constants for compatibility with older tools)
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t STREAM  = 3'd0;
  localparam seq_state_t DRAIN   = 3'd1;
  localparam seq_state_t CAPTURE = 3'd2;
  localparam seq_state_t CLEAR   = 3'd3;
  localparam seq_state_t SETTLE  = 3'd4;

  // All-ones exponent encodes both infinities and NaNs
  function automatic logic fp16_is_inf_nan(input logic [15:0] v);
    return v[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp16_dot_sequencer.sv
// Operand sequencer for the FP16 MAC. Streams operand pairs into the MAC, drains the
// pipeline at the end of each vector, captures the dot product into a held output
// register and then cancels the accumulator by injecting (-result) * 1.0.
// Optional feature: define FP16_DOT_ELEMCNT_EN to add the out_count element counter.
module fp16_dot_sequencer
  import fp16_pkg::*;
#(
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned LEN_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
`ifdef FP16_DOT_ELEMCNT_EN
  output logic [LEN_W-1:0] out_count,
`endif
  output logic             acc_err
);

  localparam int unsigned     CntW    = $clog2(MAC_LATENCY + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(MAC_LATENCY);

  seq_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     mac_a_q, mac_a_d;
  logic [15:0]     mac_b_q, mac_b_d;
  logic            out_valid_q;
  logic [15:0]     out_data_q;
  logic            acc_err_q;
  logic            in_fire;
  logic            cap_en;

  assign in_fire = in_valid && in_ready;
  // A new result may be loaded unless the previous one is still being held back
  assign cap_en  = (state_q == CAPTURE) && !(out_valid_q && !out_ready);

  // Next-state, counter and MAC operand selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mac_a_d  = FP16_ZERO;
    mac_b_d  = FP16_ZERO;
    in_ready = 1'b0;
    case (state_q)
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CntLoad;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      CAPTURE: begin
        if (cap_en) state_d = CLEAR;
      end
      CLEAR: begin
        // Negated result times one cancels the accumulator exactly for finite values
        mac_a_d = {~out_data_q[FP16_SIGN_BIT], out_data_q[FP16_EXP_MSB:FP16_MAN_LSB]};
        mac_b_d = FP16_ONE;
        state_d = SETTLE;
        cnt_d   = CntLoad;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = STREAM;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = STREAM;
    endcase
  end

  // FSM, counter and registered MAC operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STREAM;
      cnt_q   <= '0;
      mac_a_q <= FP16_ZERO;
      mac_b_q <= FP16_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
    end
  end

  // Held output register; out_valid drops on acceptance independent of state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= FP16_ZERO;
      acc_err_q   <= 1'b0;
    end else begin
      if (cap_en) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mac_result;
        if (fp16_is_inf_nan(mac_result)) acc_err_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef FP16_DOT_ELEMCNT_EN
  logic [LEN_W-1:0] elem_cnt_q;
  logic [LEN_W-1:0] out_count_q;

  // Running element count (saturating), snapshotted alongside the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt_q  <= '0;
      out_count_q <= '0;
    end else begin
      if (cap_en) begin
        out_count_q <= elem_cnt_q;
        elem_cnt_q  <= '0;
      end else if (in_fire && (elem_cnt_q != '1)) begin
        elem_cnt_q <= elem_cnt_q + LEN_W'(1);
      end
    end
  end

  assign out_count = out_count_q;
`else
  localparam int unsigned unused_len_w = LEN_W;
  logic unused_in_fire;
  assign unused_in_fire = in_fire;
`endif

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc_err   = acc_err_q;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Bench for fp16_dot_sequencer with a behavioural FP16 MAC and a scoreboard of
// expected dot products computed directly from the operand values.
`timescale 1ns/1ps
module tb_fp16_dot_sequencer;

  localparam int unsigned L     = 3;
  localparam int unsigned LEN_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic [15:0] mac_a, mac_b, mac_result;
  logic        out_valid, out_ready, acc_err;
  logic [15:0] out_data;
`ifdef FP16_DOT_ELEMCNT_EN
  logic [LEN_W-1:0] out_count;
`endif

  always #5 clk = ~clk;

  fp16_dot_sequencer #(.MAC_LATENCY(L), .LEN_W(LEN_W)) dut (
`ifdef FP16_DOT_ELEMCNT_EN
    .out_count (out_count),
`endif
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_result(mac_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_err   (acc_err)
  );

  // ---------------- FP16 <-> real helpers ----------------
  function automatic real h2r(input logic [15:0] h);
    int  e;
    int  m;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31)     v = (m == 0) ? $bitstoreal(64'h7FF0000000000000)
                                  : $bitstoreal(64'h7FF8000000000000);
    else if (e == 0) v = real'(m) * (2.0 ** (-24));
    else             v = (1.0 + real'(m) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    if (r != r) return 16'h7E00;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return 16'h0000;
    if (a >= 65520.0) return {s, 5'h1F, 10'h000};
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    if (a < 1.0) begin
      m = $rtoi(a * 1024.0 + 0.5);
      return {s, 5'd0, m[9:0]};
    end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {s, e[4:0], m[9:0]};
  endfunction

  // ---------------- behavioural MAC: sum visible L+1 edges after mac_a/mac_b change --
  real pipe [L];
  real acc;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= 0.0;
      mac_result <= 16'h0000;
      for (int i = 0; i < L; i++) pipe[i] <= 0.0;
    end else begin
      acc        <= acc + pipe[L-1];
      mac_result <= r2h(acc + pipe[L-1]);
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= h2r(mac_a) * h2r(mac_b);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic        err_model;
  logic        rnd_mode;
  logic        rdy_s;
  logic [15:0] vec_a[$];
  logic [15:0] vec_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the output is valid it must show the oldest pending result
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {15'd0, out_valid}, 32'd0);
      end else begin
        chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        chk("acc_err", {31'd0, acc_err}, {31'd0, exp_q[0].err});
`ifdef FP16_DOT_ELEMCNT_EN
        chk("out_count", {24'd0, out_count}, exp_q[0].cnt);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // One cycle: sample in_ready mid-cycle, then move to just after the next edge
  task automatic tick();
    @(negedge clk);
    rdy_s = in_ready;
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    do begin
      tick();
      t++;
    end while (!rdy_s && t < 400);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy_s) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      chk("mac_a_load", {16'd0, mac_a}, {16'd0, a});
      chk("mac_b_load", {16'd0, mac_b}, {16'd0, b});
    end
  endtask

  // Reference: exact sum of products of the queued vector, rounded once to FP16
  task automatic run_vector(input int gap_mode);
    real  sum;
    exp_t e;
    sum = 0.0;
    for (int i = 0; i < vec_a.size(); i++) sum = sum + h2r(vec_a[i]) * h2r(vec_b[i]);
    e.data    = r2h(sum);
    err_model = err_model | (e.data[14:10] == 5'h1F);
    e.err     = err_model;
    e.cnt     = (vec_a.size() > 255) ? 255 : vec_a.size();
    exp_q.push_back(e);
    for (int i = 0; i < vec_a.size(); i++) begin
      send_pair(vec_a[i], vec_b[i], i == vec_a.size() - 1);
      if (gap_mode == 1) ticks(1);
      else if (gap_mode == 2) ticks($urandom_range(0, 2));
    end
  endtask

  task automatic set_vec2(input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1);
    vec_a = {a0, a1};
    vec_b = {b0, b1};
  endtask

  task automatic set_vec1(input logic [15:0] a0, input logic [15:0] b0);
    vec_a = {a0};
    vec_b = {b0};
  endtask

  task automatic rand_vec(input int n);
    vec_a.delete();
    vec_b.delete();
    for (int i = 0; i < n; i++) begin
      vec_a.push_back(r2h(real'(int'($urandom_range(0, 16)) - 8)));
      vec_b.push_back(r2h(real'(int'($urandom_range(0, 16)) - 8)));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  // Assert reset asynchronously, check every output, then release after an edge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    exp_q.delete();
    err_model = 1'b0;
    #2;
    chk({tag, "_mac_a"}, {16'd0, mac_a}, 32'd0);
    chk({tag, "_mac_b"}, {16'd0, mac_b}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_acc_err"}, {31'd0, acc_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rnd_mode  = 1'b0;
    err_model = 1'b0;
    rdy_s     = 1'b0;
    reset     = 1'b1;
    #1;
    do_reset("init");
    ticks(2);

    // Basic dot product (1*3 + 2*4 = 11) then a vector proving the clear worked
    set_vec2(16'h3C00, 16'h4200, 16'h4000, 16'h4400);
    run_vector(0);
    set_vec1(16'h3C00, 16'h3C00);
    run_vector(0);
    wait_drain();

    // Same vector with bubbles between pairs
    set_vec2(16'h3C00, 16'h4200, 16'h4000, 16'h4400);
    run_vector(1);
    wait_drain();

    // Output backpressure with a second vector queued behind it
    out_ready = 1'b0;
    set_vec2(16'h3C00, 16'h4200, 16'h4000, 16'h4400);
    run_vector(0);
    set_vec2(16'h4000, 16'h4000, 16'hC000, 16'h3C00);
    run_vector(0);
    ticks(L + 3 + 10);
    chk("in_ready_stalled", {31'd0, rdy_s}, 32'd0);
    chk("held_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_drain();

    // Randomised vectors, gaps and backpressure
    rnd_mode = 1'b1;
    for (int v = 0; v < 25; v++) begin
      rand_vec($urandom_range(1, 6));
      run_vector(2);
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a vector
    send_pair(16'h4000, 16'h4000, 1'b0);
    send_pair(16'h4200, 16'h3C00, 1'b0);
    do_reset("mid_run");
    set_vec1(16'h4400, 16'h4000);
    run_vector(0);
    wait_drain();

    // Infinite result sets the sticky error flag
    set_vec1(16'h7C00, 16'h3C00);
    run_vector(0);
    wait_drain();
    ticks(2 * L + 6);
    chk("acc_err_sticky", {31'd0, acc_err}, 32'd1);

    // Reset while draining, then a fresh 1.0*1.0 vector
    do_reset("pre_drain");
    set_vec1(16'h3C00, 16'h3C00);
    run_vector(0);
    tick();
    chk("drain_in_ready", {31'd0, rdy_s}, 32'd0);
    chk("drain_mac_a", {16'd0, mac_a}, 32'd0);
    do_reset("in_drain");
    set_vec1(16'h3C00, 16'h3C00);
    run_vector(0);
    wait_drain();
    ticks(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
